// File: rtl/seg7_pkg.sv
// Shared types, the hex segment code table and the digit decoder
// for the seven-segment display monitor.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    // Active-high segment codes for hex digits 0..F (bit0 = a ... bit6 = g).
    localparam seg7_t SEG7_CODES [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [7:0]  invalid;
        logic [31:0] value;
    } seg7_evt_t;

    typedef enum logic [1:0] {
        IDLE_UNSTABLE,
        COUNTING,
        STABLE
    } seg7_state_t;

    // Takes an active-low bus, returns {invalid, nibble}.
    // Unknown patterns (blank included) decode to nibble 0.
    function automatic logic [4:0] seg7_decode(input seg7_t raw);
        seg7_t      lit;
        logic [4:0] res;
        lit = ~raw;
        res = 5'h10;
        for (int i = 0; i < 16; i++) begin
            if (lit == SEG7_CODES[i]) begin
                res = {1'b0, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_evt_fifo.sv
// Synchronous first-word-fall-through FIFO of decoded display events.
// Ports: clk, rst_n, push/wr_data/full, pop/rd_data/empty.
module seg7_evt_fifo
    import seg7_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  seg7_evt_t wr_data,
    output logic      full,
    input  logic      pop,
    output logic      empty,
    output seg7_evt_t rd_data
);

    localparam int AW = $clog2(DEPTH);

    seg7_evt_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/seg7_decode_monitor.sv
// Watches eight seven-segment buses, commits each new stable display
// value as a decoded event and queues it behind a valid/ready port.
// Ports: clk, rst_n (sync, active-low), i_seg0..i_seg7 (active-low
// segments, digit 0 least significant), o_value/o_invalid/o_valid/
// i_ready (event head + handshake), o_overflow (sticky drop flag),
// o_err_count (only with SEG7_ERR_COUNT_EN defined).
module seg7_decode_monitor
    import seg7_pkg::*;
#(
    parameter int G_STABLE_CYCLES = 4,
    parameter int G_FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  i_seg0,
    input  logic [6:0]  i_seg1,
    input  logic [6:0]  i_seg2,
    input  logic [6:0]  i_seg3,
    input  logic [6:0]  i_seg4,
    input  logic [6:0]  i_seg5,
    input  logic [6:0]  i_seg6,
    input  logic [6:0]  i_seg7,
    output logic [31:0] o_value,
    output logic [7:0]  o_invalid,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_overflow
`ifdef SEG7_ERR_COUNT_EN
    ,
    output logic [15:0] o_err_count
`endif
);

    localparam logic [7:0] STAB_MAX = 8'(G_STABLE_CYCLES);

    seg7_t [7:0] seg_in;
    seg7_t [7:0] raw_q;
    seg7_t [7:0] last_q;
    logic [7:0]  stab_cnt;
    logic [7:0]  cnt_next;
    seg7_state_t state_q;
    seg7_state_t state_next;
    logic        first_q;
    logic        overflow_q;
    logic        change;
    logic        commit;
    logic        pop;
    logic        full;
    logic        empty;
    seg7_evt_t   evt;
    seg7_evt_t   head;

    assign seg_in = {i_seg7, i_seg6, i_seg5, i_seg4,
                     i_seg3, i_seg2, i_seg1, i_seg0};

    // Comparing the incoming sample with raw_q lets the counter start
    // at 0 on the capture edge, so the commit lands G edges later.
    assign change = (seg_in != raw_q);

    always_comb begin
        evt = '0;
        for (int n = 0; n < 8; n++) begin
            logic [4:0] d;
            d = seg7_decode(raw_q[n]);
            evt.value[n*4 +: 4] = d[3:0];
            evt.invalid[n]      = d[4];
        end
    end

    always_comb begin
        cnt_next   = stab_cnt;
        state_next = state_q;
        commit     = 1'b0;
        if (change) begin
            cnt_next   = 8'd0;
            state_next = COUNTING;
        end else begin
            if (stab_cnt != STAB_MAX) begin
                cnt_next = stab_cnt + 8'd1;
            end
            unique case (state_q)
                IDLE_UNSTABLE,
                COUNTING: begin
                    state_next = (cnt_next == STAB_MAX) ?
                                 STABLE : COUNTING;
                end
                STABLE: begin
                    state_next = STABLE;
                end
                default: begin
                    state_next = IDLE_UNSTABLE;
                end
            endcase
            // Only the step into STABLE may commit; a return to the
            // last committed pattern is suppressed.
            if (state_q != STABLE && state_next == STABLE &&
                (first_q || raw_q != last_q)) begin
                commit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            raw_q      <= '1;
            last_q     <= '1;
            stab_cnt   <= 8'd0;
            state_q    <= IDLE_UNSTABLE;
            first_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            raw_q    <= seg_in;
            stab_cnt <= cnt_next;
            state_q  <= state_next;
            if (commit) begin
                last_q  <= raw_q;
                first_q <= 1'b0;
                if (full && !pop) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    assign pop = i_ready && !empty;

    seg7_evt_fifo #(
        .DEPTH (G_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (commit),
        .wr_data (evt),
        .full    (full),
        .pop     (pop),
        .empty   (empty),
        .rd_data (head)
    );

    assign o_valid    = !empty;
    assign o_value    = empty ? 32'd0 : head.value;
    assign o_invalid  = empty ? 8'd0 : head.invalid;
    assign o_overflow = overflow_q;

`ifdef SEG7_ERR_COUNT_EN
    logic [15:0] err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= 16'd0;
        end else if (commit && (!full || pop) &&
                     evt.invalid != 8'd0 &&
                     err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign o_err_count = err_cnt;
`endif

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Self-checking bench for seg7_decode_monitor: directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_seg7_decode_monitor;

    localparam int G = 4;
    localparam int D = 4;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg [8];
    logic        ready = 1'b0;
    logic [31:0] value;
    logic [7:0]  invalid;
    logic        valid;
    logic        overflow;
`ifdef SEG7_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seg7_decode_monitor #(
        .G_STABLE_CYCLES (G),
        .G_FIFO_DEPTH    (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_seg0     (seg[0]),
        .i_seg1     (seg[1]),
        .i_seg2     (seg[2]),
        .i_seg3     (seg[3]),
        .i_seg4     (seg[4]),
        .i_seg5     (seg[5]),
        .i_seg6     (seg[6]),
        .i_seg7     (seg[7]),
        .o_value    (value),
        .o_invalid  (invalid),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_overflow (overflow)
`ifdef SEG7_ERR_COUNT_EN
        ,
        .o_err_count (err_count)
`endif
    );

    // Reference model: an event is due once the same 56-bit sample has
    // been seen on G+1 consecutive edges and it differs from the last
    // committed one (or nothing was committed since reset).
    logic [39:0] mq [$];
    logic [55:0] m_prev;
    logic [55:0] m_last;
    int          m_run;
    bit          m_first;
    bit          m_ovf;
    int          m_err;

    function automatic logic [39:0] model_decode(input logic [55:0] v);
        logic [31:0] val;
        logic [7:0]  inv;
        val = '0;
        inv = '1;
        for (int d = 0; d < 8; d++) begin
            logic [6:0] lit;
            lit = ~v[d*7 +: 7];
            for (int h = 0; h < 16; h++) begin
                if (lit == HEX[h]) begin
                    val[d*4 +: 4] = 4'(h);
                    inv[d] = 1'b0;
                end
            end
        end
        return {inv, val};
    endfunction

    always @(posedge clk) begin
        logic [55:0] cur;
        logic [39:0] e;
        bit          pop;
        cur = {seg[7], seg[6], seg[5], seg[4],
               seg[3], seg[2], seg[1], seg[0]};
        if (!rst_n) begin
            mq.delete();
            m_prev  = '1;
            m_last  = '1;
            m_run   = 1;
            m_first = 1;
            m_ovf   = 0;
            m_err   = 0;
        end else begin
            pop = ready && (mq.size() > 0);
            if (cur == m_prev) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run  = 1;
                m_prev = cur;
            end
            if (pop) void'(mq.pop_front());
            if (m_run == G + 1 && (m_first || cur != m_last)) begin
                m_first = 0;
                m_last  = cur;
                e = model_decode(cur);
                if (mq.size() < D) begin
                    mq.push_back(e);
                    if (e[39:32] != 8'd0 && m_err < 16'hFFFF) m_err++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hex(input logic [31:0] v, input logic [7:0] blank);
        for (int n = 0; n < 8; n++) begin
            seg[n] = blank[n] ? 7'h7F : ~HEX[v[n*4 +: 4]];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ready = 1'b0;
        for (int n = 0; n < 8; n++) seg[n] = 7'h40;
        repeat (3) tick();
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%0b want=0", valid);
        end
        total++;
        if (value !== 32'd0 || invalid !== 8'd0) begin
            bad++;
            $display("FAIL reset_head got=%h/%h want=0/0", value, invalid);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovf got=%0b want=0", overflow);
        end
`ifdef SEG7_ERR_COUNT_EN
        total++;
        if (err_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_err got=%0d want=0", err_count);
        end
`endif
    endtask

    task automatic test_first_zero();
        int extra;
        rst_n = 1'b1;
        for (int i = 0; i < G; i++) begin
            tick();
            total++;
            if (valid !== 1'b0) begin
                bad++;
                $display("FAIL zero_early edge=%0d got=%0b want=0", i, valid);
            end
        end
        tick();
        total++;
        if (valid !== 1'b1) begin
            bad++;
            $display("FAIL zero_valid got=%0b want=1", valid);
        end
        total++;
        if (value !== 32'd0 || invalid !== 8'd0) begin
            bad++;
            $display("FAIL zero_head got=%h/%h want=0/0", value, invalid);
        end
        ready = 1'b1;
        tick();
        extra = 0;
        repeat (10) begin
            if (valid) extra++;
            tick();
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL zero_once got=%0d extra want=0", extra);
        end
    endtask

    task automatic watch(input int cycles, output int n,
                         output logic [31:0] v, output logic [7:0] iv);
        n = 0;
        v = '0;
        iv = '0;
        repeat (cycles) begin
            tick();
            if (valid) begin
                n++;
                v = value;
                iv = invalid;
            end
        end
    endtask

    task automatic test_value();
        int n;
        logic [31:0] v;
        logic [7:0]  iv;
        ready = 1'b1;
        set_hex(32'h12345678, 8'h00);
        watch(30, n, v, iv);
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL value_count got=%0d want=1", n);
        end
        total++;
        if (v !== 32'h12345678 || iv !== 8'h00) begin
            bad++;
            $display("FAIL value_head got=%h/%h want=12345678/00", v, iv);
        end
    endtask

    task automatic test_glitch();
        int n;
        logic [31:0] v;
        logic [7:0]  iv;
        seg[3] = 7'h08;
        repeat (2) tick();
        set_hex(32'h12345678, 8'h00);
        watch(30, n, v, iv);
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL glitch_count got=%0d want=0", n);
        end
    endtask

    task automatic test_blank();
        int n;
        logic [31:0] v;
        logic [7:0]  iv;
        set_hex(32'h12345678, 8'h20);
        watch(30, n, v, iv);
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL blank_count got=%0d want=1", n);
        end
        total++;
        if (v !== 32'h12045678 || iv !== 8'h20) begin
            bad++;
            $display("FAIL blank_head got=%h/%h want=12045678/20", v, iv);
        end
`ifdef SEG7_ERR_COUNT_EN
        total++;
        if (err_count !== 16'd1) begin
            bad++;
            $display("FAIL blank_err got=%0d want=1", err_count);
        end
`endif
    endtask

    logic [31:0] pats [5];

    task automatic test_overflow();
        bit dup;
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do begin
                pats[i] = $urandom;
                dup = 0;
                for (int j = 0; j < i; j++) if (pats[j] == pats[i]) dup = 1;
            end while (dup);
            set_hex(pats[i], 8'h00);
            repeat (G + 3) tick();
        end
        total++;
        if (overflow !== 1'b1 || valid !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flag got=%0b/%0b want=1/1", overflow, valid);
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (valid !== 1'b1 || value !== pats[i]) begin
                bad++;
                $display("FAIL ovf_drain%0d got=%0b/%h want=1/%h",
                         i, valid, value, pats[i]);
            end
            tick();
        end
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL ovf_empty got=%0b want=0", valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r [3];
        bit dup;
        int n;
        logic [31:0] v;
        logic [7:0]  iv;
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do begin
                r[i] = $urandom;
                dup = (r[i] == pats[4]);
                for (int j = 0; j < i; j++) if (r[j] == r[i]) dup = 1;
            end while (dup);
            set_hex(r[i], 8'h00);
            repeat (G + 3) tick();
        end
        total++;
        if (valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_queued got=%0b want=1", valid);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if (valid !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got=%0b/%0b want=0/0", valid, overflow);
        end
        ready = 1'b1;
        watch(30, n, v, iv);
        total++;
        if (n != 1 || v !== r[2]) begin
            bad++;
            $display("FAIL mid_rereport got=%0d/%h want=1/%h", n, v, r[2]);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [3];
        logic [6:0]  nxt [8];
        int pick;
        for (int i = 0; i < 3; i++) pool[i] = $urandom;
        for (int s = 0; s < 80; s++) begin
            pick = $urandom_range(0, 4);
            for (int n = 0; n < 8; n++) nxt[n] = seg[n];
            if (pick < 3) begin
                for (int n = 0; n < 8; n++) nxt[n] = ~HEX[pool[pick][n*4 +: 4]];
            end else if (pick == 3) begin
                for (int n = 0; n < 8; n++) nxt[n] = ~HEX[$urandom_range(0, 15)];
                if ($urandom_range(0, 2) == 0) nxt[$urandom_range(0, 7)] = 7'h7F;
            end else begin
                nxt[$urandom_range(0, 7)] = 7'($urandom);
            end
            for (int n = 0; n < 8; n++) seg[n] = nxt[n];
            repeat ($urandom_range(1, G + 4)) begin
                ready = ($urandom_range(0, 3) != 0);
                tick();
                total++;
                if (valid !== (mq.size() != 0)) begin
                    bad++;
                    $display("FAIL rnd_valid got=%0b want=%0b",
                             valid, mq.size() != 0);
                end else if (mq.size() != 0) begin
                    total++;
                    if ({invalid, value} !== mq[0]) begin
                        bad++;
                        $display("FAIL rnd_head got=%h want=%h",
                                 {invalid, value}, mq[0]);
                    end
                end
                total++;
                if (overflow !== m_ovf) begin
                    bad++;
                    $display("FAIL rnd_ovf got=%0b want=%0b", overflow, m_ovf);
                end
`ifdef SEG7_ERR_COUNT_EN
                total++;
                if (err_count !== 16'(m_err)) begin
                    bad++;
                    $display("FAIL rnd_err got=%0d want=%0d", err_count, m_err);
                end
`endif
            end
        end
    endtask

    initial begin
        for (int n = 0; n < 8; n++) seg[n] = 7'h40;
        test_reset();
        test_first_zero();
        test_value();
        test_glitch();
        test_blank();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
